// File: rtl/wb_stage.sv
// ---------------------------------------------------------------------------
// wb_stage -- register-file write-back arbiter.
//
// Merges two write sources into a single register-file write port:
//   * ALU results: no backpressure, always take priority.
//   * Load results: valid/ready handshake into a DEPTH-entry FIFO, drained
//     whenever the ALU is not presenting a result.
//
// Parameters
//   DW     register data width
//   AW     register address width
//   DEPTH  load FIFO entries (power of two, >= 2)
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   alu_valid/alu_rd/alu_data      ALU result (rd == 0 means no write)
//   mem_valid/mem_ready            load handshake
//   mem_rd/mem_data                load result (rd == 0 accepted, dropped)
//   rf_write/_addr/_data           registered register-file write port
//   pend_cnt                       number of queued loads
//   chk_addr1/chk_addr2, chk_hit   load-use hazard query
//
// Optional feature: define WB_HAZARD_EN to build the hazard comparators.
// Without it chk_hit is tied low and the query ports are unused.
// ---------------------------------------------------------------------------
module wb_stage #(
  parameter int DW    = 32,
  parameter int AW    = 5,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     alu_valid,
  input  logic [AW-1:0]            alu_rd,
  input  logic [DW-1:0]            alu_data,
  input  logic                     mem_valid,
  output logic                     mem_ready,
  input  logic [AW-1:0]            mem_rd,
  input  logic [DW-1:0]            mem_data,
  output logic                     rf_write,
  output logic [AW-1:0]            rf_write_addr,
  output logic [DW-1:0]            rf_write_data,
  output logic [$clog2(DEPTH):0]   pend_cnt,
  input  logic [AW-1:0]            chk_addr1,
  input  logic [AW-1:0]            chk_addr2,
  output logic                     chk_hit
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] fifo_rd_reg   [DEPTH];
  logic [DW-1:0] fifo_data_reg [DEPTH];
  logic [PW-1:0] wr_ptr_reg;
  logic [PW-1:0] rd_ptr_reg;
  logic [CW-1:0] cnt_reg;

  logic push;
  logic pop;
  logic alu_wr;

  // Ready depends only on the current occupancy; a pop in the same cycle
  // does not make room for a push.
  assign mem_ready = (cnt_reg < CW'(DEPTH));

  // Loads to x0 complete the handshake but are never queued.
  assign push   = mem_valid & mem_ready & (mem_rd != '0);
  // Any ALU-valid cycle owns the write slot, even an x0 result.
  assign pop    = ~alu_valid & (cnt_reg != '0);
  assign alu_wr = alu_valid & (alu_rd != '0);

  assign pend_cnt = cnt_reg;

  // FIFO storage: no reset needed, occupancy is tracked by the pointers.
  always_ff @(posedge clk) begin
    if (rst_n && push) begin
      fifo_rd_reg[wr_ptr_reg]   <= mem_rd;
      fifo_data_reg[wr_ptr_reg] <= mem_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      cnt_reg       <= '0;
      rf_write      <= 1'b0;
      rf_write_addr <= '0;
      rf_write_data <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + PW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + PW'(1);
      end
      case ({push, pop})
        2'b10:   cnt_reg <= cnt_reg + CW'(1);
        2'b01:   cnt_reg <= cnt_reg - CW'(1);
        default: cnt_reg <= cnt_reg;
      endcase

      rf_write <= alu_wr | pop;
      if (alu_wr) begin
        rf_write_addr <= alu_rd;
        rf_write_data <= alu_data;
      end else if (pop) begin
        rf_write_addr <= fifo_rd_reg[rd_ptr_reg];
        rf_write_data <= fifo_data_reg[rd_ptr_reg];
      end
    end
  end

`ifdef WB_HAZARD_EN
  // One comparator pair per slot; a slot is live when its distance from
  // the read pointer is below the occupancy count.
  logic [DEPTH-1:0] hit_vec;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_hit
    logic [PW-1:0] offset;
    logic          live;
    assign offset = PW'(gi) - rd_ptr_reg;
    assign live   = ({1'b0, offset} < cnt_reg);
    assign hit_vec[gi] = live &&
        (((chk_addr1 != '0) && (fifo_rd_reg[gi] == chk_addr1)) ||
         ((chk_addr2 != '0) && (fifo_rd_reg[gi] == chk_addr2)));
  end

  assign chk_hit = |hit_vec;
`else
  logic unused_chk;
  assign unused_chk = ^{chk_addr1, chk_addr2};
  assign chk_hit    = 1'b0;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// ---------------------------------------------------------------------------
// tb_wb_stage -- self-checking bench for wb_stage (default parameters).
// A behavioural model predicts the write-port state for each cycle; the
// prediction is queued before the clock edge and popped/compared after it.
// Directed sequences cover the named scenarios, then a random phase runs.
// ---------------------------------------------------------------------------
module tb_wb_stage;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ld_t;

  typedef struct packed {
    logic          w;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } ex_t;

  logic                   clk = 1'b0;
  logic                   rst_n;
  logic                   alu_valid;
  logic [AW-1:0]          alu_rd;
  logic [DW-1:0]          alu_data;
  logic                   mem_valid;
  logic                   mem_ready;
  logic [AW-1:0]          mem_rd;
  logic [DW-1:0]          mem_data;
  logic                   rf_write;
  logic [AW-1:0]          rf_write_addr;
  logic [DW-1:0]          rf_write_data;
  logic [$clog2(DEPTH):0] pend_cnt;
  logic [AW-1:0]          chk_addr1;
  logic [AW-1:0]          chk_addr2;
  logic                   chk_hit;

  int checks = 0;
  int errors = 0;

  ld_t           model_q[$];
  ex_t           sb_q[$];
  logic [AW-1:0] last_addr = '0;
  logic [DW-1:0] last_data = '0;

  always #5 clk = ~clk;

  wb_stage #(.DW(DW), .AW(AW), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_rd        (alu_rd),
    .alu_data      (alu_data),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_rd        (mem_rd),
    .mem_data      (mem_data),
    .rf_write      (rf_write),
    .rf_write_addr (rf_write_addr),
    .rf_write_data (rf_write_data),
    .pend_cnt      (pend_cnt),
    .chk_addr1     (chk_addr1),
    .chk_addr2     (chk_addr2),
    .chk_hit       (chk_hit)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs,
                          input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic model_hit();
    logic h;
    h = 1'b0;
`ifdef WB_HAZARD_EN
    foreach (model_q[i]) begin
      if ((chk_addr1 != '0 && model_q[i].rd == chk_addr1) ||
          (chk_addr2 != '0 && model_q[i].rd == chk_addr2))
        h = 1'b1;
    end
`endif
    return h;
  endfunction

  // One clock cycle: check combinational outputs, predict, clock, compare.
  task automatic cyc();
    ex_t e;
    ex_t got;
    ld_t l;
    #2;
    if (rst_n) begin
      check_eq("mem_ready", {63'd0, mem_ready},
               {63'd0, (model_q.size() < DEPTH)});
      check_eq("pend_cnt", 64'(pend_cnt), 64'(model_q.size()));
      check_eq("chk_hit", {63'd0, chk_hit}, {63'd0, model_hit()});
    end
    e.w = 1'b0;
    if (!rst_n) begin
      model_q.delete();
      last_addr = '0;
      last_data = '0;
    end else begin
      if (alu_valid) begin
        if (alu_rd != '0) begin
          e.w = 1'b1;
          last_addr = alu_rd;
          last_data = alu_data;
        end
      end else if (model_q.size() != 0) begin
        l = model_q.pop_front();
        e.w = 1'b1;
        last_addr = l.rd;
        last_data = l.data;
      end
      // Acceptance uses the pre-pop occupancy (no same-cycle credit).
      if (mem_valid && (model_q.size() + (e.w && !alu_valid ? 1 : 0)) < DEPTH
          && mem_rd != '0)
        model_q.push_back('{rd: mem_rd, data: mem_data});
    end
    e.addr = last_addr;
    e.data = last_data;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_eq("rf_write", {63'd0, rf_write}, {63'd0, got.w});
    check_eq("rf_addr", 64'(rf_write_addr), 64'(got.addr));
    check_eq("rf_data", 64'(rf_write_data), 64'(got.data));
    if (rf_write)
      $display("wr addr=%0d data=%08h pend=%0d t=%0t",
               rf_write_addr, rf_write_data, pend_cnt, $time);
  endtask

  task automatic idle();
    alu_valid = 1'b0;
    mem_valid = 1'b0;
    alu_rd    = '0;
    mem_rd    = '0;
  endtask

  initial begin
    int k;
    int guard;
    logic acc;
    rst_n = 1'b0;
    idle();
    alu_data  = '0;
    mem_data  = '0;
    chk_addr1 = '0;
    chk_addr2 = '0;
    cyc();
    cyc();
    check_eq("rst_pend", 64'(pend_cnt), 64'd0);
    check_eq("rst_we", {63'd0, rf_write}, 64'd0);
    rst_n = 1'b1;

    // ALU write appears one cycle later.
    alu_valid = 1'b1; alu_rd = 5'd3; alu_data = 32'hDEAD;
    cyc();
    idle();
    check_eq("alu_we", {63'd0, rf_write}, 64'd1);
    check_eq("alu_addr", 64'(rf_write_addr), 64'd3);
    check_eq("alu_data", 64'(rf_write_data), 64'hDEAD);

    // Single load through an empty FIFO: write two cycles after accept.
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 32'h55;
    cyc();
    idle();
    check_eq("ld_pend1", 64'(pend_cnt), 64'd1);
    check_eq("ld_we0", {63'd0, rf_write}, 64'd0);
    cyc();
    check_eq("ld_we", {63'd0, rf_write}, 64'd1);
    check_eq("ld_addr", 64'(rf_write_addr), 64'd7);
    check_eq("ld_data", 64'(rf_write_data), 64'h55);
    check_eq("ld_pend0", 64'(pend_cnt), 64'd0);

    // ALU busy 6 cycles while 5 loads are offered: FIFO fills to 4.
    k = 0;
    for (int i = 0; i < 6; i++) begin
      alu_valid = 1'b1; alu_rd = AW'(i + 1); alu_data = 32'h100 + i;
      mem_valid = (k < 5); mem_rd = AW'(10 + k); mem_data = 32'hA0 + k;
      #1;
      acc = mem_valid && mem_ready;
      cyc();
      if (acc) k++;
    end
    check_eq("full_acc", 64'(k), 64'd4);
    check_eq("full_pend", 64'(pend_cnt), 64'd4);
    check_eq("full_rdy", {63'd0, mem_ready}, 64'd0);
    alu_valid = 1'b0;
    guard = 0;
    while (k < 5 && guard < 20) begin
      #1;
      acc = mem_valid && mem_ready;
      cyc();
      if (acc) k++;
      guard++;
    end
    check_eq("fifth_acc", 64'(k), 64'd5);
    idle();
    for (int i = 0; i < 8; i++) cyc();

    // x0 destinations: handshake completes, nothing written or queued.
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; alu_rd = '0; mem_valid = 1'b1; mem_rd = '0;
      cyc();
      check_eq("x0_we", {63'd0, rf_write}, 64'd0);
    end
    idle();
    check_eq("x0_pend", 64'(pend_cnt), 64'd0);

    // Hazard query against a queued load held back by the ALU.
    alu_valid = 1'b1; alu_rd = 5'd1; mem_valid = 1'b1; mem_rd = 5'd9;
    mem_data = 32'h99;
    cyc();
    mem_valid = 1'b0;
    chk_addr1 = 5'd9;
    #1;
`ifdef WB_HAZARD_EN
    check_eq("hz_hit", {63'd0, chk_hit}, 64'd1);
`else
    check_eq("hz_hit", {63'd0, chk_hit}, 64'd0);
`endif
    chk_addr1 = '0; chk_addr2 = '0;
    #1;
    check_eq("hz_zero", {63'd0, chk_hit}, 64'd0);

    // Queue more loads, then reset for one cycle: nothing stale drains.
    for (int i = 0; i < 2; i++) begin
      mem_valid = 1'b1; mem_rd = AW'(20 + i); mem_data = 32'hC0 + i;
      cyc();
    end
    check_eq("pre_rst_pend", 64'(pend_cnt), 64'd3);
    rst_n = 1'b0;
    cyc();
    rst_n = 1'b1;
    idle();
    check_eq("mid_rst_pend", 64'(pend_cnt), 64'd0);
    check_eq("mid_rst_rdy", {63'd0, mem_ready}, 64'd1);
    for (int i = 0; i < 6; i++) cyc();

    // Random traffic with occasional resets.
    for (int i = 0; i < 300; i++) begin
      rst_n     = ($urandom_range(0, 39) != 0);
      alu_valid = ($urandom_range(0, 2) == 0);
      alu_rd    = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom);
      alu_data  = $urandom;
      mem_valid = ($urandom_range(0, 1) == 0);
      mem_rd    = ($urandom_range(0, 5) == 0) ? '0 : AW'($urandom_range(1, 7));
      mem_data  = $urandom;
      chk_addr1 = AW'($urandom_range(0, 7));
      chk_addr2 = AW'($urandom_range(0, 7));
      cyc();
    end
    rst_n = 1'b1;
    idle();
    for (int i = 0; i < 8; i++) cyc();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 Parameter DW, default 32, register data width.
REQ-002 Parameter AW, default 5, register address width.
REQ-003 Parameter DEPTH, default 4, memory-result FIFO entries (power of two, >=2).
REQ-004 clk  input  1  clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 alu_valid  input  1  ALU result present this cycle; no backpressure.
REQ-007 alu_rd  input  AW  ALU destination register.
REQ-008 alu_data  input  DW  ALU result.
REQ-009 mem_valid  input  1  load result offered.
REQ-010 mem_ready  output  1  stage accepts load result.
REQ-011 mem_rd  input  AW  load destination register.
REQ-012 mem_data  input  DW  load result.
REQ-013 rf_write  output  1  register-file write strobe (registered).
REQ-014 rf_write_addr  output  AW  register-file write address (registered).
REQ-015 rf_write_data  output  DW  register-file write data (registered).
REQ-016 pend_cnt  output  log2(DEPTH)+1  valid FIFO entries.
REQ-017 chk_addr1, chk_addr2  input  AW each  hazard-query addresses from operand fetch.
REQ-018 chk_hit  output  1  a queued load targets chk_addr1 or chk_addr2.

Function
REQ-019 Load handshake SHALL complete in a cycle where mem_valid and mem_ready are both 1.
REQ-020 mem_ready SHALL equal (pend_cnt < DEPTH), computed from current state only (no same-cycle pop credit).
REQ-021 An accepted load with mem_rd != 0 SHALL be pushed to the FIFO tail; with mem_rd == 0 it SHALL be accepted and discarded.
REQ-022 ALU has priority: if alu_valid=1 and alu_rd != 0 in cycle N, rf_write=1, rf_write_addr=alu_rd, rf_write_data=alu_data in cycle N+1.
REQ-023 alu_valid=1 with alu_rd == 0 SHALL produce no write and SHALL NOT free the slot for the FIFO.
REQ-024 If alu_valid=0 and FIFO non-empty in cycle N, head SHALL be popped and presented on rf_write/addr/data in cycle N+1.
REQ-025 If neither source writes in cycle N, rf_write SHALL be 0 in cycle N+1; addr/data hold previous values.
REQ-026 At most one register-file write per cycle; FIFO order SHALL be preserved.
REQ-027 Simultaneous push and pop SHALL leave pend_cnt unchanged; push only +1; pop only -1.
REQ-028 Read/write pointers SHALL be log2(DEPTH) bits and wrap modulo DEPTH.
REQ-029 Load latency through an empty FIFO with ALU idle: accept in N, rf_write in N+2.

Reset
REQ-030 While rst_n=0 at a clock edge: pend_cnt=0, pointers=0, rf_write=0, rf_write_addr=0, rf_write_data=0.
REQ-031 Reset mid-operation SHALL discard all queued loads; mem_ready=1 in the first cycle after reset release.
REQ-032 Inputs SHALL be ignored in cycles where rst_n=0.

Configuration
REQ-033 Macro WB_HAZARD_EN: when defined, chk_hit SHALL be combinationally 1 iff any valid FIFO entry has rd equal to a nonzero chk_addr1 or chk_addr2.
REQ-034 Without WB_HAZARD_EN, chk_hit SHALL be tied 0 and no comparator logic SHALL be built; ports remain present.

Verification
REQ-035 Reset, then ALU rd=3 data=0xDEAD in cycle 1 -> rf_write=1, addr=3, data=0xDEAD in cycle 2.
REQ-036 Load rd=7 data=0x55 with ALU idle -> accepted cycle 1, pend_cnt=1 cycle 2, write addr=7 data=0x55 in cycle 3, pend_cnt=0.
REQ-037 ALU valid every cycle for 6 cycles while 5 loads offered -> 4 accepted, mem_ready=0 once pend_cnt=4, ALU writes uninterrupted, loads drain in order after.
REQ-038 Loads with rd=0 and ALU with rd=0 -> handshake completes, no rf_write, pend_cnt stays 0.
REQ-039 With WB_HAZARD_EN, queued load rd=9, chk_addr1=9 -> chk_hit=1; chk_addr1=chk_addr2=0 -> chk_hit=0; without macro chk_hit=0 always.
REQ-040 FIFO holding 3 entries, rst_n=0 one cycle -> pend_cnt=0, rf_write=0, no stale entries written afterwards.
